// File: rtl/ahb_apb_pkg.sv
// Shared AHB-to-APB bridge definitions: transfer/response encodings,
// the slave response-state enum and the default APB address map.
package ahb_apb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;

   typedef enum logic [1:0] {
      RESP_OKAY = 2'd0,
      RESP_ERR1 = 2'd1,
      RESP_ERR2 = 2'd2
   } resp_state_e;

   // Default map, also used by APB_FSM_Controller and the bridge top.
   localparam logic [31:0] DEF_SLV_BASE      = 32'h8000_0000;
   localparam int          DEF_SLV_SPAN_LOG2 = 26;
   localparam int          NUM_SLAVES        = 3;

endpackage

// File: rtl/ahb_slave_interface_if.sv
// AHB-Lite bus bundle between an AHB master and the bridge slave side.
// Handshake: a transfer is accepted on an edge where Hreadyin=1 and Htrans is
// NONSEQ/SEQ; the slave stalls the master by driving Hreadyout=0.
interface ahb_slave_interface_if;
   logic        Hwrite;
   logic        Hreadyin;
   logic [1:0]  Htrans;
   logic [2:0]  Hsize;
   logic [31:0] Haddr;
   logic [31:0] Hwdata;
   logic [31:0] Hrdata;
   logic        Hreadyout;
   logic [1:0]  Hresp;

   modport master (
      output Hwrite, Hreadyin, Htrans, Hsize, Haddr, Hwdata,
      input  Hrdata, Hreadyout, Hresp
   );

   modport slave (
      input  Hwrite, Hreadyin, Htrans, Hsize, Haddr, Hwdata,
      output Hrdata, Hreadyout, Hresp
   );
endinterface

// File: rtl/ahb_addr_decoder.sv
// Combinational APB slave decode: one-hot select, out-of-window flag and
// size/address misalignment flag.
module ahb_addr_decoder
   import ahb_apb_pkg::*;
#(
   parameter logic [31:0] SLV_BASE      = DEF_SLV_BASE,
   parameter int          SLV_SPAN_LOG2 = DEF_SLV_SPAN_LOG2
) (
   input  logic [31:0] haddr,
   input  logic [2:0]  hsize,
   output logic [2:0]  sel,
   output logic        out_of_window,
   output logic        misaligned
);

   // 33-bit compare so a window ending at the top of the map cannot wrap.
   localparam logic [32:0] WIN_LO = {1'b0, SLV_BASE};
   localparam logic [32:0] WIN_HI = WIN_LO + (33'(NUM_SLAVES) << SLV_SPAN_LOG2);

   logic [1:0] idx;

   always_comb begin
      out_of_window = ({1'b0, haddr} < WIN_LO) || ({1'b0, haddr} >= WIN_HI);
      idx           = haddr[SLV_SPAN_LOG2+1 -: 2];
      sel           = 3'b000;
      if (!out_of_window) begin
         case (idx)
            2'd0:    sel = 3'b001;
            2'd1:    sel = 3'b010;
            2'd2:    sel = 3'b100;
            default: sel = 3'b000;
         endcase
      end
      misaligned = (hsize > 3'd2)
                || ((hsize == 3'd1) && haddr[0])
                || ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
   end

endmodule

// File: rtl/ahb_slave_interface.sv
// AHB-Lite slave front end of the AHB-to-APB bridge: decode, two-stage
// address/data pipeline and two-cycle ERROR response. Optional alignment
// check is enabled by defining AHB_SLV_ALIGN_CHECK_EN.
module ahb_slave_interface
   import ahb_apb_pkg::*;
#(
   parameter logic [31:0] SLV_BASE      = DEF_SLV_BASE,
   parameter int          SLV_SPAN_LOG2 = DEF_SLV_SPAN_LOG2
) (
   input  logic                   Hclk,
   input  logic                   Hresetn,
   ahb_slave_interface_if.slave   ahb,
   input  logic [31:0]            Prdata,
   input  logic                   Hreadyout_apb,
   output logic                   valid,
   output logic [31:0]            Haddr1,
   output logic [31:0]            Haddr2,
   output logic [31:0]            Hwdata1,
   output logic [31:0]            Hwdata2,
   output logic                   Hwritereg,
   output logic [2:0]             tempselx,
   output resp_state_e            resp_state_dbg
);

   logic [2:0]  dec_sel;
   logic        dec_oow;
   logic        misaligned;
   logic        active;
   logic        illegal;
   resp_state_e resp_state;
   logic        err_stall;
   logic        err_resp;

   ahb_addr_decoder #(
      .SLV_BASE      (SLV_BASE),
      .SLV_SPAN_LOG2 (SLV_SPAN_LOG2)
   ) u_dec (
      .haddr         (ahb.Haddr),
      .hsize         (ahb.Hsize),
      .sel           (dec_sel),
      .out_of_window (dec_oow),
      .misaligned    (misaligned)
   );

   assign active = ahb.Hreadyin && ((ahb.Htrans == HTRANS_NONSEQ) || (ahb.Htrans == HTRANS_SEQ));

`ifdef AHB_SLV_ALIGN_CHECK_EN
   assign illegal = active && (dec_oow || (dec_sel == 3'b000) || misaligned);
`else
   logic unused_misaligned;
   assign unused_misaligned = misaligned;
   assign illegal = active && (dec_oow || (dec_sel == 3'b000));
`endif

   assign valid          = active && !illegal && (resp_state == RESP_OKAY);
   assign tempselx       = (resp_state == RESP_OKAY) ? dec_sel : 3'b000;
   assign resp_state_dbg = resp_state;

   always_ff @(posedge Hclk) begin
      if (!Hresetn) begin
         Haddr1    <= '0;
         Haddr2    <= '0;
         Hwdata1   <= '0;
         Hwdata2   <= '0;
         Hwritereg <= 1'b0;
      end else if (ahb.Hreadyin) begin
         Haddr1    <= ahb.Haddr;
         Haddr2    <= Haddr1;
         Hwdata1   <= ahb.Hwdata;
         Hwdata2   <= Hwdata1;
         Hwritereg <= ahb.Hwrite;
      end
   end

   // ERR2 deliberately ignores new illegal transfers: the master must be idle then.
   always_ff @(posedge Hclk) begin
      if (!Hresetn) begin
         resp_state <= RESP_OKAY;
         err_stall  <= 1'b0;
         err_resp   <= 1'b0;
      end else begin
         case (resp_state)
            RESP_OKAY: begin
               if (illegal) begin
                  resp_state <= RESP_ERR1;
                  err_stall  <= 1'b1;
                  err_resp   <= 1'b1;
               end
            end
            RESP_ERR1: begin
               resp_state <= RESP_ERR2;
               err_stall  <= 1'b0;
               err_resp   <= 1'b1;
            end
            default: begin
               resp_state <= RESP_OKAY;
               err_stall  <= 1'b0;
               err_resp   <= 1'b0;
            end
         endcase
      end
   end

   assign ahb.Hrdata    = Prdata;
   assign ahb.Hresp     = err_resp ? HRESP_ERROR : HRESP_OKAY;
   assign ahb.Hreadyout = err_stall ? 1'b0 : (err_resp ? 1'b1 : Hreadyout_apb);

endmodule

// File: tb/tb_ahb_slave_interface.sv
// Bench for ahb_slave_interface: directed scenarios then random traffic,
// all compared against a behavioural model of the bridge front end.
module tb_ahb_slave_interface;
   import ahb_apb_pkg::*;

   localparam logic [31:0] BASE = 32'h8000_0000;
   localparam int          SPAN = 26;

   logic        clk;
   logic        rstn;
   logic [31:0] prdata;
   logic        apb_ready;
   logic        valid;
   logic [31:0] haddr1, haddr2, hwdata1, hwdata2;
   logic        hwritereg;
   logic [2:0]  tempselx;
   resp_state_e state_dbg;

   ahb_slave_interface_if bus ();

   ahb_slave_interface dut (
      .Hclk           (clk),
      .Hresetn        (rstn),
      .ahb            (bus.slave),
      .Prdata         (prdata),
      .Hreadyout_apb  (apb_ready),
      .valid          (valid),
      .Haddr1         (haddr1),
      .Haddr2         (haddr2),
      .Hwdata1        (hwdata1),
      .Hwdata2        (hwdata2),
      .Hwritereg      (hwritereg),
      .tempselx       (tempselx),
      .resp_state_dbg (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_mis = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // reference model: error cycles still to show, and sampled history queues
   int          err_left;
   logic [31:0] exp_q[$];
   logic [31:0] wd_q[$];
   logic        m_wr;

   function automatic logic [2:0] m_sel(input logic [31:0] a);
      longint unsigned la;
      la = a;
      if (la >= longint'(BASE) && la < longint'(BASE) + 3 * (64'd1 << SPAN))
         return 3'(1 << ((a - BASE) >> SPAN));
      return 3'b000;
   endfunction

   function automatic bit m_misaligned(input logic [2:0] sz, input logic [31:0] a);
`ifdef AHB_SLV_ALIGN_CHECK_EN
      if (sz > 3'd2) return 1'b1;
      return (a % (32'd1 << sz)) != 0;
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_reset();
      err_left = 0;
      exp_q    = '{32'h0, 32'h0};
      wd_q     = '{32'h0, 32'h0};
      m_wr     = 1'b0;
   endtask

   // driver: apply one cycle of inputs, check outputs mid-cycle, clock, advance model
   task automatic step(input logic r, input logic rdy, input logic [1:0] tr,
                       input logic [2:0] sz, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] prd, input logic apbr);
      bit   act, ill;
      logic [2:0] sel;
      @(negedge clk);
      rstn         = r;
      bus.Hreadyin = rdy;
      bus.Htrans   = tr;
      bus.Hsize    = sz;
      bus.Hwrite   = wr;
      bus.Haddr    = a;
      bus.Hwdata   = wd;
      prdata       = prd;
      apb_ready    = apbr;
      #1;
      sel = m_sel(a);
      act = rdy && tr[1];
      ill = act && (sel == 3'b000 || m_misaligned(sz, a));
      check("valid",     32'(valid),         32'(act && !ill && err_left == 0));
      check("tempselx",  32'(tempselx),      32'(err_left == 0 ? sel : 3'b000));
      check("hrdata",    bus.Hrdata,         prd);
      check("hreadyout", 32'(bus.Hreadyout), 32'(err_left == 2 ? 1'b0 : (err_left == 1 ? 1'b1 : apbr)));
      check("hresp",     32'(bus.Hresp),     32'(err_left != 0 ? HRESP_ERROR : HRESP_OKAY));
      check("haddr1",    haddr1,             exp_q[0]);
      check("haddr2",    haddr2,             exp_q[1]);
      check("hwdata1",   hwdata1,            wd_q[0]);
      check("hwdata2",   hwdata2,            wd_q[1]);
      check("hwritereg", 32'(hwritereg),     32'(m_wr));
      check("in_error",  32'(state_dbg != RESP_OKAY), 32'(err_left != 0));
      @(posedge clk);
      if (!r) begin
         model_reset();
      end else begin
         if (err_left > 0) err_left--;
         else if (ill)     err_left = 2;
         if (rdy) begin
            exp_q.push_front(a);  void'(exp_q.pop_back());
            wd_q.push_front(wd);  void'(wd_q.pop_back());
            m_wr = wr;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         step(1'b1, 1'b1, HTRANS_IDLE, 3'd2, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
   endtask

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 6))
         0:       return $urandom();
         1:       return BASE - 32'd1;
         2:       return BASE + (32'd3 << SPAN);
         3:       return BASE + (32'd3 << SPAN) - 32'd4;
         4:       return BASE + ($urandom() % (32'd3 << SPAN));
         default: return BASE + (($urandom() % (32'd3 << SPAN)) & ~32'd3);
      endcase
   endfunction

   initial begin
      rstn = 1'b0; bus.Hreadyin = 1'b1; bus.Htrans = HTRANS_NONSEQ; bus.Hsize = 3'd2;
      bus.Hwrite = 1'b0; bus.Haddr = BASE; bus.Hwdata = '0; prdata = '0; apb_ready = 1'b1;
      model_reset();
      @(posedge clk);

      // reset held with a live NONSEQ, then release
      step(1'b0, 1'b1, HTRANS_NONSEQ, 3'd2, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 1'b1);
      step(1'b0, 1'b1, HTRANS_NONSEQ, 3'd2, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 1'b1);
      step(1'b1, 1'b1, HTRANS_NONSEQ, 3'd2, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 1'b1);

      // back-to-back writes
      step(1'b1, 1'b1, HTRANS_NONSEQ, 3'd2, 1'b1, 32'h8400_0010, 32'h1234_5678, 32'h0, 1'b1);
      step(1'b1, 1'b1, HTRANS_NONSEQ, 3'd2, 1'b1, 32'h8800_0020, 32'h8765_4321, 32'h0, 1'b1);
      idle(2);

      // unmapped NONSEQ, then ERROR sequence while master idles
      step(1'b1, 1'b1, HTRANS_NONSEQ, 3'd2, 1'b0, 32'h9000_0000, 32'h0, 32'h0, 1'b1);
      idle(3);

      // Hreadyin low for 3 cycles mid-burst
      step(1'b1, 1'b1, HTRANS_NONSEQ, 3'd2, 1'b1, 32'h8000_0100, 32'hAAAA_0001, 32'h0, 1'b1);
      step(1'b1, 1'b1, HTRANS_SEQ,    3'd2, 1'b1, 32'h8000_0104, 32'hAAAA_0002, 32'h0, 1'b1);
      for (int i = 0; i < 3; i++)
         step(1'b1, 1'b0, HTRANS_SEQ, 3'd2, 1'b0, 32'h8000_0108, 32'hBBBB_0000, 32'h0, 1'b0);
      step(1'b1, 1'b1, HTRANS_SEQ,    3'd2, 1'b1, 32'h8000_0108, 32'hAAAA_0003, 32'h0, 1'b1);

      // BUSY at an unmapped address
      step(1'b1, 1'b1, HTRANS_BUSY, 3'd2, 1'b0, 32'h9000_0000, 32'h0, 32'h0, 1'b1);
      idle(1);

      // read with APB ready toggling
      step(1'b1, 1'b1, HTRANS_NONSEQ, 3'd2, 1'b0, 32'h8000_0040, 32'h0, 32'hDEAD_BEEF, 1'b0);
      step(1'b1, 1'b1, HTRANS_IDLE,   3'd2, 1'b0, 32'h8000_0040, 32'h0, 32'hDEAD_BEEF, 1'b1);

      // misaligned word access, then reset in the middle of an error
      step(1'b1, 1'b1, HTRANS_NONSEQ, 3'd2, 1'b0, 32'h8000_0002, 32'h0, 32'h0, 1'b1);
      idle(3);
      step(1'b1, 1'b1, HTRANS_NONSEQ, 3'd2, 1'b0, 32'hFFFF_FFF0, 32'h0, 32'h0, 1'b1);
      step(1'b0, 1'b1, HTRANS_IDLE,   3'd2, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
      idle(2);

      // random traffic
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 99) >= 3, $urandom_range(0, 9) >= 2,
              2'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), rand_addr(), $urandom(), $urandom(),
              1'($urandom_range(0, 1)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/ahb_slave_interface.md
# ahb_slave_interface

Upstream stage of the AHB-to-APB bridge. Samples AHB-Lite address/data phases and decodes the target APB slave. Registers a two-deep address/data pipeline and produces the `valid`/`Hwritereg`/`tempselx` qualifiers consumed by `APB_FSM_Controller`. It also returns read data and builds the AHB response, including a two-cycle ERROR response for illegal transfers.

## Interface
Parameters:
- `SLV_BASE` = 32'h8000_0000: base of the APB window.
- `SLV_SPAN_LOG2` = 26: log2 of the per-slave region size, 64 MiB.

Ports:
- `Hclk`  in  1  bridge clock. Every register updates on the rising edge.
- `Hresetn`  in  1  reset. Synchronous and active-low.
- `Hwrite`  in  1  AHB transfer direction.
- `Hreadyin`  in  1  AHB bus HREADY, observed by all slaves.
- `Htrans`  in  2  AHB transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- `Hsize`  in  3  AHB transfer size.
- `Haddr`  in  32  AHB address.
- `Hwdata`  in  32  AHB write data.
- `Prdata`  in  32  APB read data from the selected slave.
- `Hreadyout_apb`  in  1  ready from `APB_FSM_Controller`.
- `valid`  out  1  legal, active, in-window transfer in the current address phase.
- `Haddr1`, `Haddr2`  out  32  address pipeline, stages 1 and 2.
- `Hwdata1`, `Hwdata2`  out  32  write-data pipeline, stages 1 and 2.
- `Hwritereg`  out  1  registered `Hwrite`.
- `tempselx`  out  3  one-hot slave select for the current address.
- `Hrdata`  out  32  AHB read data.
- `Hreadyout`  out  1  AHB ready to the master.
- `Hresp`  out  2  AHB response: 00 OKAY, 01 ERROR.

## Operation
Address decode:
- Slave region index = `Haddr[SLV_SPAN_LOG2+1:SLV_SPAN_LOG2]`, valid only when `Haddr` lies in `[SLV_BASE, SLV_BASE + 3·2^SLV_SPAN_LOG2)`.
- Index 0 gives `tempselx`=001, index 1 gives 010, index 2 gives 100.
- Any address outside the window gives 000.

Qualifiers:
- Active transfer = `Hreadyin` && `Htrans`∈{NONSEQ, SEQ}.
- Illegal = active && (`tempselx`==000 || misaligned when the alignment check is compiled in, see Configuration).
- `valid` = active && !illegal && resp_state==OKAY. It is combinational.
- `tempselx` is combinational from `Haddr`. It is forced to 000 while resp_state≠OKAY.

Pipeline:
- While `Hreadyin`=1, each edge performs `Haddr1`←`Haddr`, `Haddr2`←`Haddr1`, `Hwdata1`←`Hwdata`, `Hwdata2`←`Hwdata1`, `Hwritereg`←`Hwrite`.
- While `Hreadyin`=0, all pipeline registers hold.

Response FSM, states OKAY, ERR1, ERR2:
- OKAY→ERR1 when illegal. Otherwise stay in OKAY.
- ERR1→ERR2 unconditionally.
- ERR2→OKAY unconditionally. ERR2 does not re-check for a new illegal transfer; this is the accepted simplification, since the master must drive IDLE after an ERROR.

Outputs:
- `Hrdata` = `Prdata`, combinational pass-through.
- In OKAY: `Hreadyout` = `Hreadyout_apb`, `Hresp` = 00.
- In ERR1: `Hreadyout`=0, `Hresp`=01.
- In ERR2: `Hreadyout`=1, `Hresp`=01.

## Timing
- Reset values:
  - All pipeline registers and `Hwritereg` are 0.
  - resp_state is OKAY, so `Hresp`=00 and `Hreadyout` follows `Hreadyout_apb`.
  - `valid` and `tempselx` are 0 only while the inputs are idle.
- Pipeline latency is one cycle to stage 1 and two cycles to stage 2.
- An illegal address phase sampled at edge N gives ERR1 during cycle N..N+1 and ERR2 during N+1..N+2. At edge N+2 the state is back in OKAY.
- An error takes priority over `Hreadyout_apb`. The APB side never sees `valid` for the errored transfer.
- BUSY and IDLE never assert `valid` and never raise an error, even at an unmapped address.
- `Hresetn` low at any edge, including mid-error, forces resp_state to OKAY and clears the pipeline on that edge.

## Configuration
- `AHB_SLV_ALIGN_CHECK_EN` defined:
  - An active transfer is also illegal if `Hsize`>2, or if `Hsize`=1 and `Haddr[0]`=1, or if `Hsize`=2 and `Haddr[1:0]`≠00.
  - Such transfers take the ERROR path.
- Macro undefined: `Hsize` is ignored and only the decode miss raises an error.

## Structure
Shared package `ahb_apb_pkg` holds:
- `HTRANS_IDLE`/`BUSY`/`NONSEQ`/`SEQ`
- `HRESP_OKAY`/`ERROR`
- the response-state enum
- default map constants shared with `APB_FSM_Controller` and the top.

Sub-module `ahb_addr_decoder` is purely combinational. It maps `Haddr`/`Hsize` to `tempselx`, the out-of-window flag and the misaligned flag.

## Test plan
- Reset held low for 2 cycles with `Htrans`=NONSEQ, `Haddr`=8000_0000 → pipeline is 0 and `Hresp`=00. After release, `valid`=1 and `tempselx`=001.
- Back-to-back NONSEQ writes to 8400_0010 and 8800_0020 with `Hwdata` 1234_5678 then 8765_4321 → `tempselx` 010 then 100. One cycle later `Haddr1`=8400_0010. Two cycles later `Haddr2`=8400_0010 and `Hwdata2`=1234_5678.
- NONSEQ to 9000_0000 → `valid`=0. Next cycle `Hreadyout`=0 with `Hresp`=01, then `Hreadyout`=1 with `Hresp`=01, then OKAY.
- `Hreadyin`=0 for 3 cycles mid-burst → `Haddr1`/`Haddr2`/`Hwdata1`/`Hwdata2` hold their values.
- BUSY at 9000_0000 → no error and `valid`=0.
- Read with `Prdata`=DEAD_BEEF and `Hreadyout_apb` toggling 0 then 1 → `Hrdata`=DEAD_BEEF and `Hreadyout` follows `Hreadyout_apb`.
- With `AHB_SLV_ALIGN_CHECK_EN`, word access to 8000_0002 → ERROR sequence. Without the macro → `valid`=1.
